// File: rtl/fft_load_if.sv
// fft_load_if: bundles the row-load, FFT-completion and result handshakes
// between fft_load_ctrl and its environment.
//
// Handshake rules (both channels): a transfer happens on a rising clk edge
// where valid && ready are both high. s_valid/s_ready carry 4-sample row
// beats. res_valid/res_ready carry the latched 16-bin result. A valid side
// never withdraws a pending transfer. res_valid holds until the handshake.
interface fft_load_if #(
  parameter int FRAME_W = 8
);
  logic               s_valid;
  logic               s_ready;
  logic               data_valid;
  logic               enable_block1;
  logic               enable_block2;
  logic               enable_block3;
  logic               enable_block4;
  logic               fft_done;
  logic               res_valid;
  logic               res_ready;
  logic [1:0]         row_idx;
  logic [FRAME_W-1:0] frame_cnt;
  logic               busy;
  logic               err;
  logic [1:0]         fsm_state;  // debug view: 0 LOAD, 1 WAIT_DONE, 2 RESULT, 3 ERROR

  // Controller side.
  modport master (
    input  s_valid, fft_done, res_ready,
    output s_ready, data_valid, enable_block1, enable_block2, enable_block3,
           enable_block4, res_valid, row_idx, frame_cnt, busy, err, fsm_state
  );

  // Upstream source / FFT data unit / result consumer side.
  modport slave (
    output s_valid, fft_done, res_ready,
    input  s_ready, data_valid, enable_block1, enable_block2, enable_block3,
           enable_block4, res_valid, row_idx, frame_cnt, busy, err, fsm_state
  );
endinterface

// File: rtl/fft_load_ctrl.sv
// fft_load_ctrl: sequences four row beats into the FFT data unit, waits for
// fft_done with a timeout, then presents the result until it is consumed.
// Optional macro FFT_LOAD_CTRL_OVERLAP_EN: while the result is held, row 0
// of the next frame may already be accepted.
module fft_load_ctrl #(
  parameter int TIMEOUT = 15,
  parameter int FRAME_W = 8
) (
  input logic        clk,
  input logic        reset,
  fft_load_if.master bus
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    LOAD      = 2'd0,
    WAIT_DONE = 2'd1,
    RESULT    = 2'd2,
    ERROR     = 2'd3
  } state_t;

  state_t             state;
  state_t             next_state;
  logic [1:0]         row_idx;
  logic [FRAME_W-1:0] frame_cnt;
  logic [CNT_W-1:0]   wait_cnt;
  logic               s_ready;
  logic               data_valid;
  logic               res_hs;

  // Next-state and handshake decode; reset forces the load path quiet.
  always_comb begin
    next_state = state;
    s_ready    = 1'b0;
    case (state)
      LOAD:    s_ready = 1'b1;
      RESULT: begin
`ifdef FFT_LOAD_CTRL_OVERLAP_EN
        // Only the first row of the next frame may overlap the result.
        s_ready = (row_idx == 2'd0);
`endif
      end
      default: s_ready = 1'b0;
    endcase
    if (reset) s_ready = 1'b0;

    data_valid = bus.s_valid && s_ready;
    res_hs     = (state == RESULT) && bus.res_ready;

    case (state)
      LOAD: begin
        if (data_valid && (row_idx == 2'd3)) next_state = WAIT_DONE;
      end
      WAIT_DONE: begin
        // fft_done wins over a timeout reached in the same cycle.
        if (bus.fft_done)              next_state = RESULT;
        else if (wait_cnt == CNT_LAST) next_state = ERROR;
      end
      RESULT: begin
        if (res_hs) next_state = LOAD;
      end
      default: next_state = state;  // ERROR is left only by reset
    endcase
  end

  // State, row pointer, frame counter and timeout counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= LOAD;
      row_idx   <= 2'd0;
      frame_cnt <= '0;
      wait_cnt  <= '0;
    end else begin
      state <= next_state;
      // Row 3 wraps naturally to 0 in the 2-bit pointer.
      if (data_valid) row_idx <= row_idx + 2'd1;
      if (res_hs) frame_cnt <= frame_cnt + FRAME_W'(1);
      // Counter restarts at 0 on every entry into WAIT_DONE.
      if ((state == WAIT_DONE) && (next_state == WAIT_DONE)) wait_cnt <= wait_cnt + CNT_W'(1);
      else wait_cnt <= '0;
    end
  end

  assign bus.s_ready       = s_ready;
  assign bus.data_valid    = data_valid;
  assign bus.enable_block1 = data_valid && (row_idx == 2'd0);
  assign bus.enable_block2 = data_valid && (row_idx == 2'd1);
  assign bus.enable_block3 = data_valid && (row_idx == 2'd2);
  assign bus.enable_block4 = data_valid && (row_idx == 2'd3);
  assign bus.res_valid     = (state == RESULT);
  assign bus.row_idx       = row_idx;
  assign bus.frame_cnt     = frame_cnt;
  assign bus.busy          = !((state == LOAD) && (row_idx == 2'd0));
  assign bus.err           = (state == ERROR);
  assign bus.fsm_state     = state;

endmodule

// File: tb/tb_fft_load_ctrl.sv
// tb_fft_load_ctrl: scenario tasks plus randomized frames for fft_load_ctrl.
// Inputs change 1ns after the rising edge; outputs are sampled 1ns later.
module tb_fft_load_ctrl;

  localparam int TIMEOUT = 15;
  localparam int FRAME_W = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fft_load_if #(.FRAME_W(FRAME_W)) bus ();

  fft_load_ctrl #(.TIMEOUT(TIMEOUT), .FRAME_W(FRAME_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- scoreboard state ----------------
  int         checks = 0;
  int         errors = 0;
  int         exp_frames = 0;      // model of completed result handshakes
  logic [3:0] exp_q[$];            // expected enable pattern per accepted beat

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [3:0] get_enables();
    return {bus.enable_block4, bus.enable_block3, bus.enable_block2, bus.enable_block1};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    bus.s_valid   = 1'b0;
    bus.fft_done  = 1'b0;
    bus.res_ready = 1'b0;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    idle_inputs();
    cycle();
    reset = 1'b0;
    exp_frames = 0;
  endtask

  task automatic load_rows(input int n);
    bus.s_valid = 1'b1;
    repeat (n) cycle();
    bus.s_valid = 1'b0;
  endtask

  // Called just after the edge accepting row 3.
  task automatic finish_frame(input int done_delay, input int hold);
    repeat (done_delay) cycle();
    bus.fft_done = 1'b1;
    cycle();
    bus.fft_done = 1'b0;
    repeat (hold) cycle();
    bus.res_ready = 1'b1;
    cycle();
    bus.res_ready = 1'b0;
    exp_frames = (exp_frames + 1) % (1 << FRAME_W);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    bus.s_valid = 1'b1;
    settle();
    checks++; if (bus.s_ready !== 1'b0) begin errors++; $display("FAIL reset_s_ready: got %b expected 0", bus.s_ready); end
    checks++; if (bus.data_valid !== 1'b0) begin errors++; $display("FAIL reset_data_valid: got %b expected 0", bus.data_valid); end
    checks++; if (get_enables() !== 4'b0000) begin errors++; $display("FAIL reset_enables: got %b expected 0000", get_enables()); end
    cycle();
    checks++; if (bus.row_idx !== 2'd0) begin errors++; $display("FAIL reset_row_idx: got %0d expected 0", bus.row_idx); end
    checks++; if (bus.frame_cnt !== '0) begin errors++; $display("FAIL reset_frame_cnt: got %0d expected 0", bus.frame_cnt); end
    checks++; if (bus.res_valid !== 1'b0) begin errors++; $display("FAIL reset_res_valid: got %b expected 0", bus.res_valid); end
    checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", bus.err); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    bus.s_valid = 1'b0;
    reset = 1'b0;
    exp_frames = 0;
    settle();
    checks++; if (bus.s_ready !== 1'b1) begin errors++; $display("FAIL post_reset_s_ready: got %b expected 1", bus.s_ready); end
  endtask

  task automatic test_basic_frame();
    logic [3:0] e;
    for (int i = 0; i < 4; i++) begin
      bus.s_valid = 1'b1;
      settle();
      e = 4'b0001 << i;
      checks++; if (get_enables() !== e) begin errors++; $display("FAIL basic_enables row %0d: got %b expected %b", i, get_enables(), e); end
      checks++; if (bus.row_idx !== 2'(i)) begin errors++; $display("FAIL basic_row_idx: got %0d expected %0d", bus.row_idx, i); end
      cycle();
    end
    bus.s_valid  = 1'b0;
    bus.fft_done = 1'b1;
    settle();
    checks++; if (bus.res_valid !== 1'b0) begin errors++; $display("FAIL basic_res_valid_early: got %b expected 0", bus.res_valid); end
    checks++; if (bus.s_ready !== 1'b0) begin errors++; $display("FAIL basic_wait_s_ready: got %b expected 0", bus.s_ready); end
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL basic_busy: got %b expected 1", bus.busy); end
    cycle();
    bus.fft_done = 1'b0;
    settle();
    checks++; if (bus.res_valid !== 1'b1) begin errors++; $display("FAIL basic_res_valid: got %b expected 1", bus.res_valid); end
    checks++; if (bus.row_idx !== 2'd0) begin errors++; $display("FAIL basic_row_idx_result: got %0d expected 0", bus.row_idx); end
    bus.res_ready = 1'b1;
    cycle();
    bus.res_ready = 1'b0;
    exp_frames = (exp_frames + 1) % (1 << FRAME_W);
    settle();
    checks++; if (bus.res_valid !== 1'b0) begin errors++; $display("FAIL basic_res_valid_fall: got %b expected 0", bus.res_valid); end
    checks++; if (bus.frame_cnt !== FRAME_W'(exp_frames)) begin errors++; $display("FAIL basic_frame_cnt: got %0d expected %0d", bus.frame_cnt, exp_frames); end
  endtask

  task automatic test_result_hold();
    load_rows(4);
    bus.fft_done = 1'b1;
    cycle();
    bus.fft_done = 1'b0;
    for (int i = 0; i < 10; i++) begin
`ifndef FFT_LOAD_CTRL_OVERLAP_EN
      bus.s_valid = 1'($urandom_range(0, 1));
`endif
      settle();
      checks++; if (bus.res_valid !== 1'b1) begin errors++; $display("FAIL hold_res_valid cycle %0d: got %b expected 1", i, bus.res_valid); end
      checks++; if (bus.frame_cnt !== FRAME_W'(exp_frames)) begin errors++; $display("FAIL hold_frame_cnt: got %0d expected %0d", bus.frame_cnt, exp_frames); end
`ifndef FFT_LOAD_CTRL_OVERLAP_EN
      checks++; if (bus.s_ready !== 1'b0) begin errors++; $display("FAIL hold_s_ready: got %b expected 0", bus.s_ready); end
      checks++; if (bus.data_valid !== 1'b0) begin errors++; $display("FAIL hold_data_valid: got %b expected 0", bus.data_valid); end
`endif
      cycle();
    end
    bus.s_valid   = 1'b0;
    bus.res_ready = 1'b1;
    cycle();
    bus.res_ready = 1'b0;
    exp_frames = (exp_frames + 1) % (1 << FRAME_W);
    settle();
    checks++; if (bus.frame_cnt !== FRAME_W'(exp_frames)) begin errors++; $display("FAIL hold_frame_cnt_after: got %0d expected %0d", bus.frame_cnt, exp_frames); end
    checks++; if (bus.res_valid !== 1'b0) begin errors++; $display("FAIL hold_res_valid_fall: got %b expected 0", bus.res_valid); end
  endtask

  task automatic test_done_at_limit();
    load_rows(4);
    repeat (TIMEOUT - 1) cycle();
    checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL limit_err_early: got %b expected 0", bus.err); end
    bus.fft_done = 1'b1;
    cycle();
    bus.fft_done = 1'b0;
    settle();
    checks++; if (bus.res_valid !== 1'b1) begin errors++; $display("FAIL limit_res_valid: got %b expected 1", bus.res_valid); end
    checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL limit_err: got %b expected 0", bus.err); end
    bus.res_ready = 1'b1;
    cycle();
    bus.res_ready = 1'b0;
    exp_frames = (exp_frames + 1) % (1 << FRAME_W);
  endtask

  task automatic test_timeout();
    int n;
    load_rows(4);
    n = 0;
    while (bus.err !== 1'b1 && n < 40) begin
      cycle();
      n++;
    end
    checks++; if (n !== TIMEOUT) begin errors++; $display("FAIL timeout_cycles: got %0d expected %0d", n, TIMEOUT); end
    bus.s_valid   = 1'b1;
    bus.fft_done  = 1'b1;
    bus.res_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      settle();
      checks++; if (bus.err !== 1'b1) begin errors++; $display("FAIL error_err: got %b expected 1", bus.err); end
      checks++; if (bus.s_ready !== 1'b0) begin errors++; $display("FAIL error_s_ready: got %b expected 0", bus.s_ready); end
      checks++; if (bus.res_valid !== 1'b0) begin errors++; $display("FAIL error_res_valid: got %b expected 0", bus.res_valid); end
      cycle();
    end
    pulse_reset();
    settle();
    checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL error_cleared: got %b expected 0", bus.err); end
    checks++; if (bus.s_ready !== 1'b1) begin errors++; $display("FAIL error_reload_s_ready: got %b expected 1", bus.s_ready); end
  endtask

  task automatic test_mid_reset();
    load_rows(2);
    settle();
    checks++; if (bus.row_idx !== 2'd2) begin errors++; $display("FAIL mid_row_idx_before: got %0d expected 2", bus.row_idx); end
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL mid_busy_before: got %b expected 1", bus.busy); end
    pulse_reset();
    settle();
    checks++; if (bus.row_idx !== 2'd0) begin errors++; $display("FAIL mid_row_idx: got %0d expected 0", bus.row_idx); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL mid_busy: got %b expected 0", bus.busy); end
    bus.s_valid = 1'b1;
    settle();
    checks++; if (get_enables() !== 4'b0001) begin errors++; $display("FAIL mid_enables: got %b expected 0001", get_enables()); end
    cycle();
    load_rows(3);
    finish_frame(0, 0);
    settle();
    checks++; if (bus.frame_cnt !== FRAME_W'(exp_frames)) begin errors++; $display("FAIL mid_frame_cnt: got %0d expected %0d", bus.frame_cnt, exp_frames); end
  endtask

  task automatic test_random_frames();
    logic [3:0] e;
    int accepted, guard, d, h;
    pulse_reset();
    for (int f = 0; f < 20; f++) begin
      accepted = 0;
      guard = 0;
      while (accepted < 4 && guard < 100) begin
        bus.s_valid  = 1'($urandom_range(0, 1));
        bus.fft_done = 1'($urandom_range(0, 1));  // must be ignored while loading
        settle();
        if (bus.s_valid) begin
          exp_q.push_back(4'b0001 << accepted);
          e = exp_q.pop_front();
          checks++; if (get_enables() !== e) begin errors++; $display("FAIL rand_enables frame %0d: got %b expected %b", f, get_enables(), e); end
          accepted++;
        end else begin
          checks++; if (get_enables() !== 4'b0000) begin errors++; $display("FAIL rand_enables_idle: got %b expected 0000", get_enables()); end
        end
        cycle();
        guard++;
      end
      checks++; if (accepted !== 4) begin errors++; $display("FAIL rand_load_budget: got %0d rows expected 4", accepted); end
      bus.s_valid  = 1'b0;
      bus.fft_done = 1'b0;
      d = $urandom_range(0, TIMEOUT - 1);
      for (int i = 0; i < d; i++) begin
        settle();
        checks++; if (bus.res_valid !== 1'b0 || bus.err !== 1'b0) begin errors++; $display("FAIL rand_wait: got res_valid %b err %b expected 0 0", bus.res_valid, bus.err); end
        cycle();
      end
      bus.fft_done = 1'b1;
      cycle();
      h = $urandom_range(0, 5);
      for (int i = 0; i < h; i++) begin
        bus.fft_done = 1'($urandom_range(0, 1));  // must be ignored in RESULT
        settle();
        checks++; if (bus.res_valid !== 1'b1) begin errors++; $display("FAIL rand_res_hold: got %b expected 1", bus.res_valid); end
        cycle();
      end
      bus.fft_done  = 1'b0;
      bus.res_ready = 1'b1;
      settle();
      checks++; if (bus.res_valid !== 1'b1) begin errors++; $display("FAIL rand_res_valid: got %b expected 1", bus.res_valid); end
      cycle();
      bus.res_ready = 1'b0;
      exp_frames = (exp_frames + 1) % (1 << FRAME_W);
      settle();
      checks++; if (bus.res_valid !== 1'b0) begin errors++; $display("FAIL rand_res_fall: got %b expected 0", bus.res_valid); end
      checks++; if (bus.frame_cnt !== FRAME_W'(exp_frames)) begin errors++; $display("FAIL rand_frame_cnt: got %0d expected %0d", bus.frame_cnt, exp_frames); end
    end
  endtask

`ifdef FFT_LOAD_CTRL_OVERLAP_EN
  task automatic test_overlap();
    load_rows(4);
    bus.fft_done = 1'b1;
    cycle();
    bus.fft_done = 1'b0;
    bus.s_valid  = 1'b1;
    settle();
    checks++; if (get_enables() !== 4'b0001) begin errors++; $display("FAIL ovl_enables: got %b expected 0001", get_enables()); end
    cycle();
    for (int i = 0; i < 3; i++) begin
      settle();
      checks++; if (bus.data_valid !== 1'b0) begin errors++; $display("FAIL ovl_second_beat: got %b expected 0", bus.data_valid); end
      checks++; if (bus.row_idx !== 2'd1) begin errors++; $display("FAIL ovl_row_idx: got %0d expected 1", bus.row_idx); end
      checks++; if (bus.res_valid !== 1'b1) begin errors++; $display("FAIL ovl_res_valid: got %b expected 1", bus.res_valid); end
      cycle();
    end
    bus.s_valid   = 1'b0;
    bus.res_ready = 1'b1;
    cycle();
    bus.res_ready = 1'b0;
    exp_frames = (exp_frames + 1) % (1 << FRAME_W);
    bus.s_valid = 1'b1;
    settle();
    checks++; if (bus.frame_cnt !== FRAME_W'(exp_frames)) begin errors++; $display("FAIL ovl_frame_cnt: got %0d expected %0d", bus.frame_cnt, exp_frames); end
    checks++; if (get_enables() !== 4'b0010) begin errors++; $display("FAIL ovl_next_enables: got %b expected 0010", get_enables()); end
    cycle();
    load_rows(2);
    finish_frame(0, 0);
    // Row-0 beat and result handshake in the same cycle.
    load_rows(4);
    bus.fft_done = 1'b1;
    cycle();
    bus.fft_done  = 1'b0;
    bus.s_valid   = 1'b1;
    bus.res_ready = 1'b1;
    settle();
    checks++; if (get_enables() !== 4'b0001) begin errors++; $display("FAIL ovl_coincide_enables: got %b expected 0001", get_enables()); end
    cycle();
    bus.s_valid   = 1'b0;
    bus.res_ready = 1'b0;
    exp_frames = (exp_frames + 1) % (1 << FRAME_W);
    settle();
    checks++; if (bus.res_valid !== 1'b0) begin errors++; $display("FAIL ovl_coincide_res_valid: got %b expected 0", bus.res_valid); end
    checks++; if (bus.row_idx !== 2'd1) begin errors++; $display("FAIL ovl_coincide_row_idx: got %0d expected 1", bus.row_idx); end
    checks++; if (bus.frame_cnt !== FRAME_W'(exp_frames)) begin errors++; $display("FAIL ovl_coincide_frame_cnt: got %0d expected %0d", bus.frame_cnt, exp_frames); end
    load_rows(3);
    finish_frame(0, 0);
  endtask
`endif

  task automatic test_frame_wrap();
    pulse_reset();
    repeat (255) begin
      load_rows(4);
      finish_frame(0, 0);
    end
    settle();
    checks++; if (bus.frame_cnt !== FRAME_W'(exp_frames)) begin errors++; $display("FAIL wrap_255: got %0d expected %0d", bus.frame_cnt, exp_frames); end
    load_rows(4);
    finish_frame(0, 0);
    settle();
    checks++; if (bus.frame_cnt !== FRAME_W'(exp_frames)) begin errors++; $display("FAIL wrap_0: got %0d expected %0d", bus.frame_cnt, exp_frames); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_basic_frame();
    test_result_hold();
    test_done_at_limit();
    test_timeout();
    test_mid_reset();
    test_random_frames();
`ifdef FFT_LOAD_CTRL_OVERLAP_EN
    test_overlap();
`endif
    test_frame_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fft_load_ctrl.md
FFT_LOAD_CTRL -- requirements
Module: fft_load_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 15, meaning the maximum WAIT_DONE cycles allowed without fft_done before entering ERROR.
REQ-002 SHALL have parameter FRAME_W, default 8, meaning the width of frame_cnt.
REQ-003 SHALL have a single clock and a synchronous, active-high reset.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 reset  input  1  synchronous active-high reset.
REQ-006 s_valid  input  1  upstream 4-sample row beat valid.
REQ-007 s_ready  output  1  controller accepts a row beat.
REQ-008 data_valid  output  1  row-load strobe to the FFT data unit.
REQ-009 enable_block1, enable_block2, enable_block3, enable_block4  output  1 each  one-hot row-slot select to the FFT data unit.
REQ-010 fft_done  input  1  completion flag from the FFT data unit.
REQ-011 res_valid  output  1  16-bin FFT result is latched and stable.
REQ-012 res_ready  input  1  downstream consumes the result.
REQ-013 row_idx  output  2  index of the next row to load.
REQ-014 frame_cnt  output  FRAME_W  count of completed result handshakes, wraps to 0.
REQ-015 busy  output  1  high in any state other than LOAD with row_idx=0.
REQ-016 err  output  1  sticky timeout flag.

Function
REQ-017 FSM states SHALL be LOAD, WAIT_DONE, RESULT and ERROR.
REQ-018 LOAD: s_ready=1; a beat is accepted when s_valid&&s_ready; row_idx increments on each accepted beat.
REQ-019 data_valid SHALL be combinational s_valid&&s_ready.
REQ-020 enable_blockN SHALL be 1 only when data_valid=1 and row_idx=N-1; otherwise all enables are 0 (one-hot or zero, never multi-hot).
REQ-021 Accepting a beat with row_idx=3 SHALL move LOAD to WAIT_DONE and wrap row_idx to 0.
REQ-022 WAIT_DONE: s_ready=0; a cycle counter starts at 0 on entry.
REQ-023 WAIT_DONE with fft_done=1 SHALL move to RESULT at the next edge; this is the same edge at which the data unit latches its outputs.
REQ-024 WAIT_DONE with fft_done=0 and counter=TIMEOUT-1 SHALL move to ERROR.
REQ-025 If fft_done=1 and the counter equals TIMEOUT-1 in the same cycle, fft_done SHALL take priority.
REQ-026 RESULT: res_valid=1 (registered); it SHALL hold until res_valid&&res_ready.
REQ-027 On the RESULT handshake: frame_cnt increments (wrapping at 2^FRAME_W), the FSM returns to LOAD, and res_valid falls at the next edge.
REQ-028 fft_done asserted in LOAD or RESULT SHALL be ignored.
REQ-029 ERROR: s_ready=0, res_valid=0, err=1; the state is left only by reset.
REQ-030 Result latency SHALL be 2 cycles: from the edge accepting row 3 to res_valid=1, given a compliant data unit.

Reset
REQ-031 While reset=1, at the clock edge the FSM SHALL go to LOAD, with row_idx=0, frame_cnt=0, res_valid=0, err=0 and the timeout counter=0.
REQ-032 While reset=1, s_ready, data_valid and all enables SHALL be 0 combinationally.
REQ-033 Reset asserted mid-frame SHALL discard any partially loaded rows; the next frame starts at row 0.

Configuration
REQ-034 Macro FFT_LOAD_CTRL_OVERLAP_EN defined: in RESULT with row_idx=0, s_ready=1, and one row-0 beat SHALL be accepted (enable_block1) with row_idx set to 1 while res_valid is held. After the handshake the FSM enters LOAD with row_idx preserved. If the row-0 beat and res_ready coincide, both SHALL complete in the same cycle.
REQ-035 Macro FFT_LOAD_CTRL_OVERLAP_EN undefined: s_ready=0 throughout RESULT and no overlap logic SHALL exist.

Verification
REQ-036 s_valid held high for 4 cycles after reset, fft_done pulsed on cycle 5 -> enables 1000,0100,0010,0001 on cycles 1-4; res_valid=1 from cycle 6; row_idx=0.
REQ-037 res_ready=0 for 10 cycles then 1 -> res_valid held high 10 cycles; frame_cnt goes 0->1 on the handshake; s_ready=0 throughout (macro undefined).
REQ-038 fft_done tied 0 after 4 accepted rows -> ERROR after 15 WAIT_DONE cycles; err=1; s_ready=0 until reset.
REQ-039 255 complete frames, then 1 more -> frame_cnt reads 255, then wraps to 0.
REQ-040 Reset pulse after 2 accepted rows -> row_idx=0, busy=0; the next beat drives enable_block1.
REQ-041 Macro FFT_LOAD_CTRL_OVERLAP_EN defined, s_valid=1 during RESULT with res_ready=0 -> exactly one beat accepted (enable_block1) and row_idx=1; after res_ready, the next beat drives enable_block2.
